// File: rtl/display_scanner.sv
// Converts an 8-bit binary value to three BCD digits (one double-dabble step per cycle)
// and time-multiplexes them onto a 4-position common-anode display with leading-zero blanking.
module display_scanner #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] value_in,
  input  logic       value_valid,
  output logic       busy,
  output logic [3:0] digit,
  output logic [3:0] AN
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CONVERT = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  localparam logic [19:0] REFRESH_LAST = 20'(REFRESH_DIV - 1);

  logic [1:0]  state_reg;
  logic [7:0]  shift_reg;
  logic [11:0] bcd_reg;
  logic [2:0]  step_reg;
  logic [3:0]  ones_reg;
  logic [3:0]  tens_reg;
  logic [3:0]  hund_reg;
  logic [19:0] refresh_reg;
  logic [1:0]  sel_reg;

  logic [11:0] bcd_adj;
  logic [19:0] dd_next;

  // Add-3 correction on each BCD nibble before the shift.
  for (genvar gi = 0; gi < 3; gi++) begin : g_adj
    assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                (bcd_reg[gi*4 +: 4] + 4'd3) : bcd_reg[gi*4 +: 4];
  end

  assign dd_next = {bcd_adj[10:0], shift_reg, 1'b0};
  assign busy    = (state_reg != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      shift_reg <= 8'd0;
      bcd_reg   <= 12'd0;
      step_reg  <= 3'd0;
      ones_reg  <= 4'd0;
      tens_reg  <= 4'd0;
      hund_reg  <= 4'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (value_valid) begin
            shift_reg <= value_in;
            bcd_reg   <= 12'd0;
            step_reg  <= 3'd0;
            state_reg <= CONVERT;
          end
        end
        CONVERT: begin
          bcd_reg   <= dd_next[19:8];
          shift_reg <= dd_next[7:0];
          step_reg  <= step_reg + 3'd1;
          if (step_reg == 3'd7) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          // Display registers change only here, so partial results never show.
          hund_reg  <= bcd_reg[11:8];
          tens_reg  <= bcd_reg[7:4];
          ones_reg  <= bcd_reg[3:0];
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_reg <= 20'd0;
      sel_reg     <= 2'd0;
    end else if (refresh_reg == REFRESH_LAST) begin
      refresh_reg <= 20'd0;
      sel_reg     <= sel_reg + 2'd1;
    end else begin
      refresh_reg <= refresh_reg + 20'd1;
    end
  end

  always_comb begin
    digit = 4'd0;
    AN    = 4'b1111;
    case (sel_reg)
      2'd0: begin
        digit = ones_reg;
        AN    = 4'b1110;
      end
      2'd1: begin
        digit = tens_reg;
        if ((hund_reg != 4'd0) || (tens_reg != 4'd0)) AN = 4'b1101;
      end
      2'd2: begin
        digit = hund_reg;
        if (hund_reg != 4'd0) AN = 4'b1011;
      end
      default: begin
        digit = 4'd0;
        AN    = 4'b1111;
      end
    endcase
  end

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner: one instance with REFRESH_DIV=4 for the display
// and conversion checks, one with REFRESH_DIV=1 for back-to-back conversions.
module tb_display_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] v4_value, v1_value;
  logic       v4_valid, v1_valid;
  logic       busy4, busy1;
  logic [3:0] digit4, digit1, an4, an1;

  int checks = 0;
  int errors = 0;
  int n = 0;

  always #5 clk = ~clk;

  display_scanner #(.REFRESH_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .value_in(v4_value), .value_valid(v4_valid),
    .busy(busy4), .digit(digit4), .AN(an4)
  );

  display_scanner #(.REFRESH_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .value_in(v1_value), .value_valid(v1_valid),
    .busy(busy1), .digit(digit1), .AN(an1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model of the DIV=4 scan position: n edges after reset release, select = (n/4)%4.
  task automatic wait_sel4(input int s);
    for (int i = 0; i < 16 && ((n / 4) % 4) != s; i++) tick();
  endtask

  task automatic check_disp(input string tag, input logic [15:0] digs, input logic [15:0] ans);
    for (int s = 0; s < 4; s++) begin
      wait_sel4(s);
      check({tag, " digit"}, {4'd0, digit4}, {4'd0, digs[s*4 +: 4]});
      check({tag, " an"}, {4'd0, an4}, {4'd0, ans[s*4 +: 4]});
    end
  endtask

  task automatic convert4(input logic [7:0] v);
    v4_value = v;
    v4_valid = 1'b1;
    tick();
    v4_valid = 1'b0;
    repeat (9) tick();
  endtask

  initial begin
    logic [15:0] seq_d;
    logic [15:0] seq_a;
    logic [15:0] d123;
    logic [15:0] a123;
    logic [3:0]  ed, ea;
    int          s;

    rst_n = 1'b0;
    v4_value = 8'd0; v4_valid = 1'b0;
    v1_value = 8'd0; v1_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy4", {7'd0, busy4}, 8'd0);
    check("reset digit4", {4'd0, digit4}, 8'd0);
    check("reset an4", {4'd0, an4}, 8'h0e);
    check("reset busy1", {7'd0, busy1}, 8'd0);
    check("reset an1", {4'd0, an1}, 8'h0e);
    rst_n = 1'b1;
    n = 0;

    // 255: busy for exactly 9 cycles, then the full scan pattern
    check("255 idle busy", {7'd0, busy4}, 8'd0);
    v4_value = 8'd255;
    v4_valid = 1'b1;
    tick();
    v4_valid = 1'b0;
    check("255 busy c1", {7'd0, busy4}, 8'd1);
    check("255 digit hold", {4'd0, digit4}, 8'd0);
    for (int i = 2; i <= 9; i++) begin
      tick();
      check($sformatf("255 busy c%0d", i), {7'd0, busy4}, 8'd1);
      check("255 digit hold", {4'd0, digit4}, 8'd0);
    end
    tick();
    check("255 busy end", {7'd0, busy4}, 8'd0);
    for (int i = 0; i < 16 && (n % 16) != 0; i++) tick();
    seq_d = 16'h0255;
    seq_a = 16'hFBDE;
    for (int i = 0; i < 16; i++) begin
      s = i / 4;
      check($sformatf("255 scan digit c%0d", i), {4'd0, digit4}, {4'd0, seq_d[s*4 +: 4]});
      check($sformatf("255 scan an c%0d", i), {4'd0, an4}, {4'd0, seq_a[s*4 +: 4]});
      tick();
    end

    convert4(8'd7);
    check_disp("v7", 16'h0007, 16'hFFFE);

    convert4(8'd100);
    check_disp("v100", 16'h0100, 16'hFBDE);

    // 42 with a 99 request during busy's 4th cycle, which must be dropped
    v4_value = 8'd42;
    v4_valid = 1'b1;
    tick();
    v4_valid = 1'b0;
    repeat (3) tick();
    v4_value = 8'd99;
    v4_valid = 1'b1;
    tick();
    v4_valid = 1'b0;
    repeat (5) tick();
    check("v42 busy end", {7'd0, busy4}, 8'd0);
    tick();
    check("v42 no queued", {7'd0, busy4}, 8'd0);
    check_disp("v42", 16'h0042, 16'hFFDE);

    // 200 completes, 37 is aborted by reset after step 5
    convert4(8'd200);
    check_disp("v200", 16'h0200, 16'hFBDE);
    v4_value = 8'd37;
    v4_valid = 1'b1;
    tick();
    v4_valid = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("abort digit", {4'd0, digit4}, 8'd0);
    check("abort an", {4'd0, an4}, 8'h0e);
    check("abort busy", {7'd0, busy4}, 8'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    v4_valid = 1'b1;
    tick();
    v4_valid = 1'b0;
    check("post-reset accept", {7'd0, busy4}, 8'd1);
    check("post-reset digit", {4'd0, digit4}, 8'd0);
    for (int i = 2; i <= 9; i++) begin
      tick();
      check($sformatf("post-reset busy c%0d", i), {7'd0, busy4}, 8'd1);
      check("post-reset digit", {4'd0, digit4}, 8'd0);
    end
    tick();
    check("post-reset busy end", {7'd0, busy4}, 8'd0);
    check_disp("v37", 16'h0037, 16'hFFDE);

    // REFRESH_DIV=1 with value_valid held: accept every 10 cycles, select every cycle
    d123 = 16'h0123;
    a123 = 16'hFBDE;
    v1_value = 8'd123;
    v1_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      s = n % 4;
      if (i < 9) begin
        ed = 4'd0;
        ea = (s == 0) ? 4'b1110 : 4'b1111;
      end else begin
        ed = d123[s*4 +: 4];
        ea = a123[s*4 +: 4];
      end
      check($sformatf("div1 busy e%0d", i), {7'd0, busy1}, {7'd0, ((i % 10) != 9)});
      check($sformatf("div1 digit e%0d", i), {4'd0, digit1}, {4'd0, ed});
      check($sformatf("div1 an e%0d", i), {4'd0, an1}, {4'd0, ea});
    end
    v1_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
